video_tap_mux: RTL and testbench



---
 rtl/video_tap_mux.sv | 174 +++++++++++++++++
 tb/tb_video_tap_mux.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_tap_mux.sv
// video_tap_mux: frame-synchronous N-way video tap selector.
// Forwards one tap through a registered output stage, regenerating blank/vde
// from the selected coordinates. Tap changes wait for the active stream's last
// frame pixel, then hold the output black until the new tap's frame origin.
// Optional feature macro: VIDEO_TAP_MUX_BORDER_EN (draws a BORDER_COLOR frame
// around the active area as a visual tap-switch marker).
module video_tap_mux #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_TAPS   = 4,
    parameter int H_ACTIVE   = -1,
    parameter int V_ACTIVE   = -1,
    parameter int H_FRAME    = -1,
    parameter int V_FRAME    = -1,
    parameter logic [DATA_WIDTH*3-1:0] BORDER_COLOR = 24'hFF0000,
    localparam int unsigned VW = $clog2(V_FRAME),
    localparam int unsigned HW = $clog2(H_FRAME),
    localparam int unsigned SW = $clog2(NUM_TAPS)
) (
    input  logic                           pixelclk,
    input  logic                           rst,
    input  logic [SW-1:0]                  sel,
    input  logic [NUM_TAPS*DATA_WIDTH*3-1:0] in_data,
    input  logic [NUM_TAPS*VW-1:0]         in_vcnt,
    input  logic [NUM_TAPS*HW-1:0]         in_hcnt,
    output logic [DATA_WIDTH*3-1:0]        out_data,
    output logic [VW-1:0]                  out_vcnt,
    output logic [HW-1:0]                  out_hcnt,
    output logic                           out_hblank,
    output logic                           out_vblank,
    output logic                           out_vde,
    output logic                           out_field,
    output logic [SW-1:0]                  out_active_tap,
    output logic                           out_switching
);

    localparam int unsigned PW        = DATA_WIDTH * 3;
    localparam int unsigned FRAME_PIX = H_FRAME * V_FRAME;
    localparam int unsigned CW        = $clog2(FRAME_PIX + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_EOF = 2'd1,
        ST_SYNC     = 2'd2
    } state_t;

    state_t          state;
    logic [SW-1:0]   cur_tap;
    logic [SW-1:0]   pend;
    logic [CW-1:0]   sync_cnt;

    logic [PW-1:0]   tap_data [NUM_TAPS];
    logic [VW-1:0]   tap_vcnt [NUM_TAPS];
    logic [HW-1:0]   tap_hcnt [NUM_TAPS];

    logic [PW-1:0]   sel_data;
    logic [VW-1:0]   sel_vcnt;
    logic [HW-1:0]   sel_hcnt;
    logic [PW-1:0]   pix_data;
    logic            hblank_c;
    logic            vblank_c;
    logic            vde_c;
    logic            at_eof;
    logic            at_sof;
    logic            sel_ok;
    logic            sync_timeout;

    // Unpack the flat tap buses into per-tap arrays
    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        assign tap_data[k] = in_data[k*PW +: PW];
        assign tap_vcnt[k] = in_vcnt[k*VW +: VW];
        assign tap_hcnt[k] = in_hcnt[k*HW +: HW];
    end

    // Route the current tap and derive timing flags ahead of the output register
    always_comb begin
        sel_data     = tap_data[cur_tap];
        sel_vcnt     = tap_vcnt[cur_tap];
        sel_hcnt     = tap_hcnt[cur_tap];
        hblank_c     = (sel_hcnt >= HW'(H_ACTIVE));
        vblank_c     = (sel_vcnt >= VW'(V_ACTIVE));
        vde_c        = !hblank_c && !vblank_c;
        at_eof       = (sel_vcnt == VW'(V_FRAME - 1)) && (sel_hcnt == HW'(H_FRAME - 1));
        at_sof       = (sel_vcnt == '0) && (sel_hcnt == '0);
        sel_ok       = (32'(sel) < 32'(NUM_TAPS));
        sync_timeout = (sync_cnt == CW'(FRAME_PIX));
    end

`ifdef VIDEO_TAP_MUX_BORDER_EN
    // Paint the outermost active rows/columns with the border colour
    always_comb begin
        pix_data = sel_data;
        if (vde_c && ((sel_hcnt == '0) || (sel_hcnt == HW'(H_ACTIVE - 1)) ||
                      (sel_vcnt == '0) || (sel_vcnt == VW'(V_ACTIVE - 1)))) begin
            pix_data = BORDER_COLOR;
        end
    end
`else
    localparam logic [PW-1:0] unused_border_color = BORDER_COLOR;
    assign pix_data = sel_data;
`endif

    // Switch-control state machine and registered output stage
    always_ff @(posedge pixelclk or posedge rst) begin
        if (rst) begin
            state          <= ST_SYNC;
            cur_tap        <= '0;
            pend           <= '0;
            sync_cnt       <= '0;
            out_data       <= '0;
            out_vcnt       <= '0;
            out_hcnt       <= '0;
            out_hblank     <= 1'b1;
            out_vblank     <= 1'b1;
            out_vde        <= 1'b0;
            out_field      <= 1'b0;
            out_active_tap <= '0;
            out_switching  <= 1'b1;
        end else begin
            out_data       <= pix_data;
            out_vcnt       <= sel_vcnt;
            out_hcnt       <= sel_hcnt;
            out_hblank     <= hblank_c;
            out_vblank     <= vblank_c;
            out_vde        <= vde_c;
            out_field      <= 1'b0;
            out_active_tap <= cur_tap;
            out_switching  <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (sel_ok && (sel != cur_tap)) begin
                        pend          <= sel;
                        state         <= ST_WAIT_EOF;
                        out_switching <= 1'b1;
                    end
                end
                ST_WAIT_EOF: begin
                    out_switching <= 1'b1;
                    // End of frame wins over a same-cycle sel change
                    if (at_eof) begin
                        cur_tap  <= pend;
                        sync_cnt <= '0;
                        state    <= ST_SYNC;
                    end else if (sel_ok) begin
                        if (sel == cur_tap) begin
                            state         <= ST_RUN;
                            out_switching <= 1'b0;
                        end else begin
                            pend <= sel;
                        end
                    end
                end
                ST_SYNC: begin
                    // Origin pixel (or timeout) is emitted normally
                    if (at_sof || sync_timeout) begin
                        state <= ST_RUN;
                    end else begin
                        sync_cnt      <= sync_cnt + CW'(1);
                        out_data      <= '0;
                        out_hblank    <= 1'b1;
                        out_vblank    <= 1'b1;
                        out_vde       <= 1'b0;
                        out_switching <= 1'b1;
                    end
                end
                default: begin
                    state         <= ST_SYNC;
                    sync_cnt      <= '0;
                    out_switching <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_video_tap_mux.sv
// Self-checking bench for video_tap_mux: free-running per-tap counters,
// randomized sel traffic and a behavioural switch model.
module tb_video_tap_mux;

    localparam int H_ACT = 8;
    localparam int H_FRM = 10;
    localparam int V_ACT = 4;
    localparam int V_FRM = 6;
    localparam int FRM   = H_FRM * V_FRM;
`ifdef VIDEO_TAP_MUX_BORDER_EN
    localparam bit BORDER_ON = 1'b1;
`else
    localparam bit BORDER_ON = 1'b0;
`endif
    localparam logic [38:0] RESET_VEC = {24'h0, 3'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1};

    logic        pixelclk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  sel = 2'd0;
    logic [1:0]  sel3 = 2'd0;
    logic [95:0] in_data;
    logic [11:0] in_vcnt;
    logic [15:0] in_hcnt;

    logic [23:0] out_data;
    logic [2:0]  out_vcnt;
    logic [3:0]  out_hcnt;
    logic        out_hblank, out_vblank, out_vde, out_field, out_switching;
    logic [1:0]  out_active_tap;

    logic [23:0] d2_data;
    logic [2:0]  d2_vcnt;
    logic [3:0]  d2_hcnt;
    logic        d2_hblank, d2_vblank, d2_vde, d2_field, d2_switching;
    logic [1:0]  d2_active_tap;

    int tv [4];
    int th [4];
    bit frozen [4];

    int m_active, m_pend, m_cnt;
    bit m_black;
    logic [38:0] exp_vec;
    logic [38:0] act_vec;
    logic [38:0] act2_vec;
    int errors = 0;
    int checks = 0;

    always #5 pixelclk = ~pixelclk;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            in_data[k*24 +: 24] = 24'(k*16 + th[k]);
            in_vcnt[k*3 +: 3]   = 3'(tv[k]);
            in_hcnt[k*4 +: 4]   = 4'(th[k]);
        end
    end

    assign act_vec  = {out_data, out_vcnt, out_hcnt, out_hblank, out_vblank, out_vde,
                       out_field, out_active_tap, out_switching};
    assign act2_vec = {d2_data, d2_vcnt, d2_hcnt, d2_hblank, d2_vblank, d2_vde,
                       d2_field, d2_active_tap, d2_switching};

    video_tap_mux #(
        .DATA_WIDTH(8), .NUM_TAPS(4),
        .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .H_FRAME(H_FRM), .V_FRAME(V_FRM)
    ) dut (
        .pixelclk(pixelclk), .rst(rst), .sel(sel),
        .in_data(in_data), .in_vcnt(in_vcnt), .in_hcnt(in_hcnt),
        .out_data(out_data), .out_vcnt(out_vcnt), .out_hcnt(out_hcnt),
        .out_hblank(out_hblank), .out_vblank(out_vblank), .out_vde(out_vde),
        .out_field(out_field), .out_active_tap(out_active_tap),
        .out_switching(out_switching)
    );

    // Three-tap instance: sel value 3 is out of range there
    video_tap_mux #(
        .DATA_WIDTH(8), .NUM_TAPS(3),
        .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .H_FRAME(H_FRM), .V_FRAME(V_FRM)
    ) dut3 (
        .pixelclk(pixelclk), .rst(rst), .sel(sel3),
        .in_data(in_data[71:0]), .in_vcnt(in_vcnt[8:0]), .in_hcnt(in_hcnt[11:0]),
        .out_data(d2_data), .out_vcnt(d2_vcnt), .out_hcnt(d2_hcnt),
        .out_hblank(d2_hblank), .out_vblank(d2_vblank), .out_vde(d2_vde),
        .out_field(d2_field), .out_active_tap(d2_active_tap),
        .out_switching(d2_switching)
    );

    function automatic logic [23:0] exp_pix(int k, int v, int h);
        logic [23:0] d;
        d = 24'(k*16 + h);
        if (BORDER_ON && h < H_ACT && v < V_ACT &&
            (h == 0 || h == H_ACT-1 || v == 0 || v == V_ACT-1))
            d = 24'hFF0000;
        return d;
    endfunction

    function automatic logic [38:0] norm_vec(int k, int v, int h, bit sw);
        logic hb, vb;
        hb = (h >= H_ACT);
        vb = (v >= V_ACT);
        return {exp_pix(k, v, h), 3'(v), 4'(h), hb, vb, !hb && !vb, 1'b0, 2'(k), sw};
    endfunction

    function automatic logic [38:0] black_vec(int k, int v, int h);
        return {24'h0, 3'(v), 4'(h), 1'b1, 1'b1, 1'b0, 1'b0, 2'(k), 1'b1};
    endfunction

    // Reference: follow the active tap; a request waits for that tap's last
    // frame pixel, then black until the new tap's origin or one frame of time.
    task automatic model_eval();
        int v, h, s;
        bit sv;
        if (rst) begin
            m_active = 0; m_pend = -1; m_black = 1'b1; m_cnt = 0;
            exp_vec = RESET_VEC;
            return;
        end
        v = tv[m_active]; h = th[m_active];
        s = int'(sel); sv = (s < 4);
        if (m_black) begin
            if ((v == 0 && h == 0) || m_cnt == FRM) begin
                m_black = 1'b0;
                exp_vec = norm_vec(m_active, v, h, 1'b0);
            end else begin
                m_cnt++;
                exp_vec = black_vec(m_active, v, h);
            end
        end else if (m_pend >= 0) begin
            if (v == V_FRM-1 && h == H_FRM-1) begin
                exp_vec = norm_vec(m_active, v, h, 1'b1);
                m_active = m_pend; m_pend = -1; m_black = 1'b1; m_cnt = 0;
            end else begin
                if (sv) m_pend = (s == m_active) ? -1 : s;
                exp_vec = norm_vec(m_active, v, h, m_pend >= 0);
            end
        end else begin
            if (sv && s != m_active) m_pend = s;
            exp_vec = norm_vec(m_active, v, h, m_pend >= 0);
        end
    endtask

    task automatic set_pos(int k, int p);
        tv[k] = p / H_FRM;
        th[k] = p % H_FRM;
    endtask

    // One pixel: predict, clock, advance the tap counters
    task automatic step();
        model_eval();
        @(posedge pixelclk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (!frozen[k]) begin
                th[k]++;
                if (th[k] == H_FRM) begin
                    th[k] = 0;
                    tv[k] = (tv[k] + 1) % V_FRM;
                end
            end
        end
    endtask

    task automatic test_reset();
        int blk;
        bit done;
        rst = 1'b1; sel = 2'd0; sel3 = 2'd0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (act_vec !== exp_vec) begin
                errors++; $display("FAIL reset_state: got %h expected %h", act_vec, exp_vec);
            end
        end
        set_pos(0, 35);
        set_pos(1, int'($urandom_range(0, FRM-1)));
        set_pos(2, (35 + 20 + int'($urandom_range(0, 30))) % FRM);
        set_pos(3, int'($urandom_range(0, FRM-1)));
        rst = 1'b0;
        blk = 0; done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            step();
            checks++;
            if (act_vec !== exp_vec) begin
                errors++; $display("FAIL reset_release: got %h expected %h", act_vec, exp_vec);
            end
            if (out_switching === 1'b1 && out_vde === 1'b0) blk++;
            else if (out_switching === 1'b0) begin
                done = 1'b1;
                checks++;
                if (blk != 25 || out_vde !== 1'b1 || out_vcnt !== 3'd0 || out_hcnt !== 4'd0) begin
                    errors++;
                    $display("FAIL reset_first_pixel: got black=%0d vde=%b v=%0d h=%0d expected black=25 vde=1 v=0 h=0",
                             blk, out_vde, out_vcnt, out_hcnt);
                end
            end
        end
        checks++;
        if (!done) begin
            errors++; $display("FAIL reset_timeout: got switching=%b expected 0 within 80 cycles", out_switching);
        end
        step();
        checks++;
        if (out_data !== (BORDER_ON ? 24'hFF0000 : 24'h000001)) begin
            errors++; $display("FAIL reset_second_pixel: got %h expected %h", out_data,
                               BORDER_ON ? 24'hFF0000 : 24'h000001);
        end
    endtask

    task automatic test_cancel();
        int a, n;
        a = m_active;
        n = 0;
        while (!(tv[a] == 1 && th[a] == 0) && n < 80) begin
            step(); n++;
            checks++;
            if (act_vec !== exp_vec) begin
                errors++; $display("FAIL cancel_wait: got %h expected %h", act_vec, exp_vec);
            end
        end
        sel = 2'((a + 2) % 4);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (act_vec !== exp_vec) begin
                errors++; $display("FAIL cancel_request: got %h expected %h", act_vec, exp_vec);
            end
        end
        sel = 2'(a);
        for (int i = 0; i < 70; i++) begin
            step();
            checks++;
            if (act_vec !== exp_vec || out_active_tap !== 2'(a)) begin
                errors++; $display("FAIL cancel_run: got %h expected %h tap %0d", act_vec, exp_vec, a);
            end
        end
        checks++;
        if (out_switching !== 1'b0) begin
            errors++; $display("FAIL cancel_switching: got %b expected 0", out_switching);
        end
    endtask

    task automatic test_switch();
        int n, pv, ph;
        bit seen, done;
        n = 0;
        while (!(tv[m_active] == 1 && th[m_active] == 4) && n < 80) begin
            step(); n++;
            checks++;
            if (act_vec !== exp_vec) begin
                errors++; $display("FAIL switch_wait: got %h expected %h", act_vec, exp_vec);
            end
        end
        sel = 2'd2;
        seen = 1'b0; done = 1'b0; pv = -1; ph = -1;
        for (int i = 0; i < 200 && !done; i++) begin
            step();
            checks++;
            if (act_vec !== exp_vec) begin
                errors++; $display("FAIL switch_run: got %h expected %h", act_vec, exp_vec);
            end
            if (!seen && out_active_tap === 2'd2) begin
                seen = 1'b1;
                checks++;
                if (pv != 5 || ph != 9 || out_data !== 24'h0 || out_vde !== 1'b0) begin
                    errors++;
                    $display("FAIL switch_first_black: got prev=(%0d,%0d) data=%h vde=%b expected prev=(5,9) data=0 vde=0",
                             pv, ph, out_data, out_vde);
                end
            end else if (seen && out_switching === 1'b0) begin
                done = 1'b1;
                checks++;
                if (out_data !== (BORDER_ON ? 24'hFF0000 : 24'h000020) ||
                    out_vcnt !== 3'd0 || out_hcnt !== 4'd0) begin
                    errors++;
                    $display("FAIL switch_origin: got data=%h v=%0d h=%0d expected data=%h v=0 h=0",
                             out_data, out_vcnt, out_hcnt, BORDER_ON ? 24'hFF0000 : 24'h000020);
                end
            end
            pv = int'(out_vcnt); ph = int'(out_hcnt);
        end
        checks++;
        if (!done) begin
            errors++; $display("FAIL switch_timeout: got tap=%0d switching=%b expected tap 2 settled",
                               out_active_tap, out_switching);
        end
    endtask

    task automatic test_timeout();
        int blk;
        bit done;
        frozen[3] = 1'b1; tv[3] = 2; th[3] = 2;
        sel = 2'd3;
        blk = 0; done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            step();
            checks++;
            if (act_vec !== exp_vec) begin
                errors++; $display("FAIL timeout_run: got %h expected %h", act_vec, exp_vec);
            end
            if (out_active_tap === 2'd3 && out_switching === 1'b1) blk++;
            else if (out_active_tap === 2'd3 && out_switching === 1'b0) begin
                done = 1'b1;
                checks++;
                if (blk != FRM || out_data !== 24'h000032 || out_vde !== 1'b1) begin
                    errors++;
                    $display("FAIL timeout_release: got black=%0d data=%h vde=%b expected black=%0d data=000032 vde=1",
                             blk, out_data, out_vde, FRM);
                end
            end
        end
        checks++;
        if (!done) begin
            errors++; $display("FAIL timeout_bound: got tap=%0d switching=%b expected release", out_active_tap, out_switching);
        end
        frozen[3] = 1'b0;
    endtask

    task automatic test_border();
        int seen;
        bit s03, s37, s11, s40;
        sel = 2'd1;
        seen = 0; s03 = 0; s37 = 0; s11 = 0; s40 = 0;
        for (int i = 0; i < 250 && seen < 4; i++) begin
            step();
            checks++;
            if (act_vec !== exp_vec) begin
                errors++; $display("FAIL border_run: got %h expected %h", act_vec, exp_vec);
            end
            if (out_active_tap === 2'd1 && out_switching === 1'b0) begin
                if (!s03 && out_vcnt === 3'd0 && out_hcnt === 4'd3) begin
                    s03 = 1; seen++; checks++;
                    if (out_data !== (BORDER_ON ? 24'hFF0000 : 24'h000013)) begin
                        errors++; $display("FAIL border_0_3: got %h expected %h", out_data,
                                           BORDER_ON ? 24'hFF0000 : 24'h000013);
                    end
                end
                if (!s37 && out_vcnt === 3'd3 && out_hcnt === 4'd7) begin
                    s37 = 1; seen++; checks++;
                    if (out_data !== (BORDER_ON ? 24'hFF0000 : 24'h000017)) begin
                        errors++; $display("FAIL border_3_7: got %h expected %h", out_data,
                                           BORDER_ON ? 24'hFF0000 : 24'h000017);
                    end
                end
                if (!s11 && out_vcnt === 3'd1 && out_hcnt === 4'd1) begin
                    s11 = 1; seen++; checks++;
                    if (out_data !== 24'h000011) begin
                        errors++; $display("FAIL border_1_1: got %h expected 000011", out_data);
                    end
                end
                if (!s40 && out_vcnt === 3'd4 && out_hcnt === 4'd0) begin
                    s40 = 1; seen++; checks++;
                    if (out_data !== 24'h000010 || out_vde !== 1'b0) begin
                        errors++; $display("FAIL border_4_0: got data=%h vde=%b expected data=000010 vde=0",
                                           out_data, out_vde);
                    end
                end
            end
        end
        checks++;
        if (seen != 4) begin
            errors++; $display("FAIL border_coverage: got %0d points expected 4", seen);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) sel = 2'($urandom_range(0, 3));
            step();
            checks++;
            if (act_vec !== exp_vec) begin
                errors++; $display("FAIL random_run: cycle %0d got %h expected %h", i, act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bit done;
        n = 0;
        sel = 2'((m_active + 1) % 4);
        while (!(m_pend >= 0 && !m_black) && n < 200) begin
            step(); n++;
            checks++;
            if (act_vec !== exp_vec) begin
                errors++; $display("FAIL midrst_wait: got %h expected %h", act_vec, exp_vec);
            end
        end
        rst = 1'b1;
        step();
        checks++;
        if (act_vec !== RESET_VEC || exp_vec !== RESET_VEC) begin
            errors++; $display("FAIL midrst_state: got %h expected %h", act_vec, RESET_VEC);
        end
        rst = 1'b0; sel = 2'd0;
        done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            step();
            checks++;
            if (act_vec !== exp_vec) begin
                errors++; $display("FAIL midrst_release: got %h expected %h", act_vec, exp_vec);
            end
            if (out_switching === 1'b0) begin
                done = 1'b1;
                checks++;
                if (out_active_tap !== 2'd0 || out_vcnt !== 3'd0 || out_hcnt !== 4'd0) begin
                    errors++; $display("FAIL midrst_resume: got tap=%0d v=%0d h=%0d expected tap 0 at (0,0)",
                                       out_active_tap, out_vcnt, out_hcnt);
                end
            end
        end
        checks++;
        if (!done) begin
            errors++; $display("FAIL midrst_timeout: got switching=%b expected 0", out_switching);
        end
    endtask

    task automatic test_invalid_sel();
        int pv, ph;
        for (int i = 0; i < 70; i++) begin
            step();
            checks++;
            if (act_vec !== exp_vec) begin
                errors++; $display("FAIL invalid_settle: got %h expected %h", act_vec, exp_vec);
            end
        end
        sel3 = 2'd3;
        for (int i = 0; i < 80; i++) begin
            pv = tv[0]; ph = th[0];
            step();
            checks++;
            if (act2_vec !== norm_vec(0, pv, ph, 1'b0)) begin
                errors++; $display("FAIL invalid_sel: got %h expected %h", act2_vec, norm_vec(0, pv, ph, 1'b0));
            end
        end
        sel3 = 2'd0;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            tv[k] = 0; th[k] = 0; frozen[k] = 1'b0;
        end
        m_active = 0; m_pend = -1; m_cnt = 0; m_black = 1'b1;
        exp_vec = RESET_VEC;
        test_reset();
        test_cancel();
        test_switch();
        test_timeout();
        test_border();
        test_random();
        test_reset_mid();
        test_invalid_sel();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
